bus_arbiter: RTL and testbench

Round-robin arbiter sharing the single CPU-side bus port (address, write enable, write data, read data) of the Bridge/DRAM datapath between N requesting masters, e.g. the CPU fetch-side loader and a DMA/debug engine. It serialises requests, drives the slave port from the winning master, and returns a registered acknowledge with captured read data. Optional bus locking lets one master issue back-to-back transfers, bounded by a hold limit.

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/bus_arbiter_rr_picker.sv | 24 ++
 rtl/bus_arbiter.sv | 132 +++++++++++++
 tb/tb_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state encodings and the slave bus width.
package bus_arbiter_pkg;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first asserted request at or after ptr.
module rr_picker #(
  parameter int N_MASTER = 2,
  parameter int OWN_W    = 1
) (
  input  logic [N_MASTER-1:0] req,
  input  logic [OWN_W-1:0]    ptr,
  output logic                valid,
  output logic [OWN_W-1:0]    idx
);

  // Scan from the farthest candidate back to ptr so the closest request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_MASTER]) begin
        valid = 1'b1;
        idx   = OWN_W'((int'(ptr) + k) % N_MASTER);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one slave bus port between N masters, with optional
// bounded bus locking and a registered acknowledge carrying captured read data.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter  int N_MASTER = 2,
  parameter  int MAX_HOLD = 16,
  localparam int OWN_W    = ($clog2(N_MASTER) > 1) ? $clog2(N_MASTER) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_MASTER-1:0]       m_req,
  input  logic [N_MASTER-1:0]       m_lock,
  input  logic [BUS_W*N_MASTER-1:0] m_addr,
  input  logic [N_MASTER-1:0]       m_wen,
  input  logic [BUS_W*N_MASTER-1:0] m_wdata,
  output logic [N_MASTER-1:0]       m_gnt,
  output logic [N_MASTER-1:0]       m_ack,
  output logic [BUS_W-1:0]          m_rdata,
  output logic [BUS_W-1:0]          s_addr,
  output logic                      s_wen,
  output logic [BUS_W-1:0]          s_wdata,
  input  logic [BUS_W-1:0]          s_rdata,
  output logic [OWN_W-1:0]          owner,
  output logic                      busy
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [OWN_W-1:0]    r_owner;
  logic [OWN_W-1:0]    r_rr_ptr;
  logic [OWN_W-1:0]    w_pick_idx;
  logic [OWN_W-1:0]    w_ptr_inc;
  logic                w_pick_valid;
  logic [HC_W-1:0]     r_hold_cnt;
  logic                w_hold_lim;
  logic [N_MASTER-1:0] r_ack;
  logic [N_MASTER-1:0] w_owner_oh;
  logic [BUS_W-1:0]    r_rdata;
  logic [BUS_W-1:0]    w_addr;
  logic [BUS_W-1:0]    w_wdata;
  logic                w_wen;
  logic                w_own_req;
  logic                w_own_lock;
  logic                w_xfer;

  rr_picker #(
    .N_MASTER (N_MASTER),
    .OWN_W    (OWN_W)
  ) u_rr_picker (
    .req   (m_req),
    .ptr   (r_rr_ptr),
    .valid (w_pick_valid),
    .idx   (w_pick_idx)
  );

  // Select the owner's request fields; the one-hot form doubles as grant/ack vector.
  always_comb begin
    w_addr     = '0;
    w_wdata    = '0;
    w_wen      = 1'b0;
    w_owner_oh = '0;
    for (int k = 0; k < N_MASTER; k++) begin
      if (r_owner == OWN_W'(k)) begin
        w_addr        = m_addr[k*BUS_W +: BUS_W];
        w_wdata       = m_wdata[k*BUS_W +: BUS_W];
        w_wen         = m_wen[k];
        w_owner_oh[k] = 1'b1;
      end
    end
  end

  assign w_own_req  = |(m_req & w_owner_oh);
  assign w_own_lock = |(m_lock & w_owner_oh);
  assign w_hold_lim = (r_hold_cnt >= HC_W'(MAX_HOLD));
  assign w_ptr_inc  = (r_owner == OWN_W'(N_MASTER - 1)) ? '0 : r_owner + 1'b1;
  assign w_xfer     = (r_state == ST_XFER);

  assign s_addr  = w_xfer ? w_addr  : '0;
  assign s_wdata = w_xfer ? w_wdata : '0;
  assign s_wen   = w_wen & w_xfer & ~rst;
  assign m_gnt   = (r_state != ST_IDLE) ? w_owner_oh : '0;
  assign m_ack   = r_ack;
  assign m_rdata = r_rdata;
  assign owner   = r_owner;
  assign busy    = (r_state != ST_IDLE);

  // Release is checked before a new locked request so the hold limit is never exceeded.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_valid) w_state_nxt = ST_XFER;
      ST_XFER: w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = (w_own_lock && !w_hold_lim) ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (!w_own_lock || w_hold_lim) w_state_nxt = ST_IDLE;
        else if (w_own_req)            w_state_nxt = ST_XFER;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_xfer ? w_owner_oh : '0;
      if (w_xfer) r_rdata <= s_rdata;
      if (r_state == ST_IDLE) begin
        if (w_pick_valid) begin
          r_owner    <= w_pick_idx;
          r_hold_cnt <= '0;
        end
      end else begin
        if (!w_hold_lim) r_hold_cnt <= r_hold_cnt + 1'b1;
        if (w_state_nxt == ST_IDLE) begin
          r_rr_ptr <= w_ptr_inc;
          r_owner  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random bench for bus_arbiter with a transaction scoreboard and reference memory.
module tb_bus_arbiter;

  localparam int N     = 4;
  localparam int MH    = 16;
  localparam int OW    = 2;
  localparam int BOUND = (N - 1) * (MH + 2) + 4;

  typedef struct {
    int          idx;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
  } txn_t;

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_req;
  logic [N-1:0]    m_lock;
  logic [32*N-1:0] m_addr;
  logic [N-1:0]    m_wen;
  logic [32*N-1:0] m_wdata;
  logic [N-1:0]    m_gnt;
  logic [N-1:0]    m_ack;
  logic [31:0]     m_rdata;
  logic [31:0]     s_addr;
  logic            s_wen;
  logic [31:0]     s_wdata;
  logic [31:0]     s_rdata;
  logic [OW-1:0]   owner;
  logic            busy;

  logic [31:0] smem [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16];
  logic        poke_en;
  logic [3:0]  poke_a;
  logic [31:0] poke_d;

  txn_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   wen_cycles = 0;
  int   wt[N];
  int   ack_cnt[N];
  bit   renew[N];
  bit   just_acked[N];

  bus_arbiter #(.N_MASTER(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_lock(m_lock), .m_addr(m_addr),
    .m_wen(m_wen), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack),
    .m_rdata(m_rdata), .s_addr(s_addr), .s_wen(s_wen), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .owner(owner), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read slave memory, word-indexed by address bits [5:2].
  assign s_rdata = smem[s_addr[5:2]];
  always @(posedge clk) begin
    if (poke_en)    smem[poke_a] <= poke_d;
    else if (s_wen) smem[s_addr[5:2]] <= s_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req_start(input int i, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic lk);
    txn_t t;
    m_addr[i*32 +: 32]  = a;
    m_wdata[i*32 +: 32] = d;
    m_wen[i]  = w;
    m_lock[i] = lk;
    m_req[i]  = 1'b1;
    wt[i]     = 0;
    t.idx = i; t.addr = a; t.wen = w; t.wdata = d;
    q.push_back(t);
  endtask

  task automatic step();
    int   f;
    txn_t t;
    @(negedge clk);
    chk("gnt_onehot0", 32'($onehot0(m_gnt)), 32'd1);
    chk("ack_onehot0", 32'($onehot0(m_ack)), 32'd1);
    if (s_wen) wen_cycles++;
    for (int i = 0; i < N; i++) if (m_req[i]) wt[i]++;
    for (int i = 0; i < N; i++) begin
      if (m_ack[i]) begin
        ack_cnt[i]++;
        f = -1;
        foreach (q[k]) if (f < 0 && q[k].idx == i) f = k;
        chk("ack_has_txn", 32'(f >= 0), 32'd1);
        if (f >= 0) begin
          t = q[f];
          q.delete(f);
          chk($sformatf("rdata_m%0d", i), m_rdata, ref_mem[t.addr[5:2]]);
          chk($sformatf("wait_m%0d_le_bound", i), 32'(wt[i] <= BOUND), 32'd1);
          if (t.wen) ref_mem[t.addr[5:2]] = t.wdata;
          if (renew[i]) begin
            q.push_back(t);
            wt[i] = 0;
          end else begin
            m_req[i]      = 1'b0;
            just_acked[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (q.size() == 0 && !busy) break;
      step();
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    chk("drain_idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_req = '0;
    m_lock = '0;
    q.delete();
    for (int i = 0; i < N; i++) begin renew[i] = 1'b0; just_acked[i] = 1'b0; end
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int a0;
    int w0;
    rst = 1'b1; m_req = '0; m_lock = '0; m_wen = '0; m_addr = '0; m_wdata = '0;
    poke_en = 1'b1; poke_a = 4'd0; poke_d = 32'hDEADBEEF;
    for (int k = 0; k < 16; k++) ref_mem[k] = 32'h0;
    ref_mem[0] = 32'hDEADBEEF;
    for (int i = 0; i < N; i++) begin wt[i] = 0; ack_cnt[i] = 0; end
    do_reset();
    poke_en = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt", 32'(m_gnt), 32'd0);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_saddr", s_addr, 32'd0);
    chk("rst_swen", 32'(s_wen), 32'd0);

    // Single read
    req_start(0, 32'h4000, 1'b0, 32'h0, 1'b0);
    step();
    chk("rd_xfer_gnt", 32'(m_gnt), 32'h1);
    chk("rd_xfer_saddr", s_addr, 32'h4000);
    chk("rd_xfer_swen", 32'(s_wen), 32'd0);
    chk("rd_xfer_busy", 32'(busy), 32'd1);
    chk("rd_xfer_ack", 32'(m_ack), 32'd0);
    step();
    chk("rd_ack", 32'(m_ack), 32'h1);
    chk("rd_ack_rdata", m_rdata, 32'hDEADBEEF);
    chk("rd_ack_swen", 32'(s_wen), 32'd0);
    chk("rd_ack_gnt", 32'(m_gnt), 32'h1);
    step();
    chk("rd_idle_busy", 32'(busy), 32'd0);
    chk("rd_idle_gnt", 32'(m_gnt), 32'd0);

    // Simultaneous requests from reset, then a tie with the pointer past m0
    do_reset();
    req_start(0, 32'h10, 1'b0, 32'h0, 1'b0);
    req_start(1, 32'h14, 1'b0, 32'h0, 1'b0);
    step();
    chk("tie1_first_m0", 32'(m_gnt), 32'h1);
    step();
    step();
    chk("tie1_gap_idle", 32'(busy), 32'd0);
    step();
    chk("tie1_second_m1", 32'(m_gnt), 32'h2);
    chk("tie1_owner1", 32'(owner), 32'd1);
    step();
    step();
    req_start(0, 32'h18, 1'b0, 32'h0, 1'b0);
    step(); step(); step();
    req_start(0, 32'h1C, 1'b0, 32'h0, 1'b0);
    req_start(1, 32'h20, 1'b0, 32'h0, 1'b0);
    step();
    chk("tie2_first_m1", 32'(m_gnt), 32'h2);
    wait_idle(20);

    // Write gating
    w0 = wen_cycles;
    req_start(1, 32'h8000, 1'b1, 32'h12345678, 1'b0);
    step();
    chk("wr_xfer_swen", 32'(s_wen), 32'd1);
    chk("wr_xfer_saddr", s_addr, 32'h8000);
    chk("wr_xfer_swdata", s_wdata, 32'h12345678);
    step();
    chk("wr_ack_swen", 32'(s_wen), 32'd0);
    step();
    chk("wr_one_cycle", 32'(wen_cycles - w0), 32'd1);
    req_start(0, 32'h8000, 1'b0, 32'h0, 1'b0);
    wait_idle(20);

    // Reset asserted during XFER of a write
    req_start(1, 32'h8004, 1'b1, 32'hCAFEF00D, 1'b0);
    step();
    chk("rstx_pre_swen", 32'(s_wen), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstx_swen_gated", 32'(s_wen), 32'd0);
    q.delete();
    m_req = '0;
    step();
    chk("rstx_busy", 32'(busy), 32'd0);
    chk("rstx_ack_dropped", 32'(m_ack), 32'd0);
    chk("rstx_rdata", m_rdata, 32'd0);
    rst = 1'b0;
    req_start(0, 32'h8004, 1'b0, 32'h0, 1'b0);
    wait_idle(20);

    // Locked burst with continuous request, forced release at the hold limit
    req_start(0, 32'h30, 1'b0, 32'h0, 1'b1);
    renew[0] = 1'b1;
    step();
    req_start(1, 32'h34, 1'b0, 32'h0, 1'b0);
    a0 = ack_cnt[0];
    for (int k = 0; k < 80 && !m_gnt[1]; k++) step();
    chk("burst_m1_granted", 32'(m_gnt[1]), 32'd1);
    chk("burst_m0_acks", 32'(ack_cnt[0] - a0), 32'd6);
    renew[0] = 1'b0;
    m_lock[0] = 1'b0;
    wait_idle(60);

    // Lock held with no request
    req_start(0, 32'h38, 1'b0, 32'h0, 1'b1);
    step();
    step();
    step();
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_gnt", 32'(m_gnt), 32'h1);
    step();
    chk("hold_stays", 32'(busy), 32'd1);
    m_lock[0] = 1'b0;
    step();
    chk("unlock_busy", 32'(busy), 32'd0);
    chk("unlock_gnt", 32'(m_gnt), 32'd0);

    // Random stress
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        m_lock[i] = ($urandom_range(0, 2) == 0);
        if (!m_req[i] && !just_acked[i] && $urandom_range(0, 3) == 0)
          req_start(i, 32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)),
                    $urandom, m_lock[i]);
        just_acked[i] = 1'b0;
      end
    end
    m_lock = '0;
    wait_idle(N * BOUND + 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
